// File: rtl/oserdes_link_ctrl.sv
// Sequences one 8:1 OSERDES transmit lane: serializer reset, fixed training word,
// then valid/ready forwarding of user bytes with idle-word insertion.
module oserdes_link_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned TRAIN_CYCLES = 64,
  parameter logic [7:0]  TRAIN_WORD   = 8'h5C,
  parameter logic [7:0]  IDLE_WORD    = 8'hBC,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        serdes_rst_o,
  output logic        oce_o,
  output logic [7:0]  d_o,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic        retrain_i,
  output logic        link_up_o,
  output logic [1:0]  state_o,
  output logic [15:0] word_count_o
);

  typedef enum logic [1:0] {
    StReset  = 2'b00,
    StTrain  = 2'b01,
    StActive = 2'b10,
    StUnused = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] RstLoad   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TrainLoad = CNT_W'(TRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        d_q, d_d;
  logic [15:0]       wc_q, wc_d;
  logic              xfer;

  assign s_ready_o = (state_q == StActive) && !retrain_i && !rst_i;
  assign xfer      = s_valid_i && s_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_d          = IDLE_WORD;
    wc_d         = wc_q;
    serdes_rst_o = 1'b1;
    oce_o        = 1'b0;
    link_up_o    = 1'b0;
    unique case (state_q)
      StReset: begin
        if (cnt_q == '0) begin
          state_d = StTrain;
          cnt_d   = TrainLoad;
          d_d     = TRAIN_WORD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StTrain: begin
        serdes_rst_o = 1'b0;
        oce_o        = 1'b1;
        if (retrain_i) begin
          cnt_d = TrainLoad;
          d_d   = TRAIN_WORD;
        end else if (cnt_q == '0) begin
          // First ACTIVE cycle shows the idle word.
          state_d = StActive;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          d_d   = TRAIN_WORD;
        end
      end
      StActive: begin
        serdes_rst_o = 1'b0;
        oce_o        = 1'b1;
        link_up_o    = 1'b1;
        if (retrain_i) begin
          state_d = StTrain;
          cnt_d   = TrainLoad;
          d_d     = TRAIN_WORD;
        end else if (xfer) begin
          d_d  = s_data_i;
          wc_d = wc_q + 16'd1;
        end
      end
      StUnused: begin
        state_d = StReset;
        cnt_d   = RstLoad;
      end
      default: begin
        state_d = StReset;
        cnt_d   = RstLoad;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StReset;
      cnt_q   <= RstLoad;
      d_q     <= IDLE_WORD;
      wc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wc_q    <= wc_d;
    end
  end

  assign d_o          = d_q;
  assign state_o      = state_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_oserdes_link_ctrl.sv
// Scoreboard bench for oserdes_link_ctrl with RST_CYCLES=4, TRAIN_CYCLES=8.
module tb_oserdes_link_ctrl;

  localparam logic [1:0] SRst = 2'b00;
  localparam logic [1:0] STrn = 2'b01;
  localparam logic [1:0] SAct = 2'b10;
  localparam logic [7:0] TW   = 8'h5C;
  localparam logic [7:0] IW   = 8'hBC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serdes_rst, oce, s_ready, link_up, s_valid = 1'b0, retrain = 1'b0;
  logic [7:0]  d, s_data = 8'h00;
  logic [1:0]  state;
  logic [15:0] word_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] st;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  oserdes_link_ctrl #(
    .RST_CYCLES  (4),
    .TRAIN_CYCLES(8),
    .TRAIN_WORD  (8'h5C),
    .IDLE_WORD   (8'hBC),
    .CNT_W       (16)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .serdes_rst_o(serdes_rst),
    .oce_o       (oce),
    .d_o         (d),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .retrain_i   (retrain),
    .link_up_o   (link_up),
    .state_o     (state),
    .word_count_o(word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check s_ready, push the outputs expected after
  // the edge, then pop and compare them just after the edge.
  task automatic cyc(input logic v, input logic [7:0] dat, input logic rt, input logic r,
                     input logic exp_rdy, input logic [7:0] nd, input logic [1:0] nst);
    exp_t e;
    s_valid = v;
    s_data  = dat;
    retrain = rt;
    rst     = r;
    @(negedge clk);
    check_eq("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
    exp_q.push_back('{d: nd, st: nst});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("d", {24'd0, d}, {24'd0, e.d});
    check_eq("state", {30'd0, state}, {30'd0, e.st});
    check_eq("serdes_rst", {31'd0, serdes_rst}, {31'd0, e.st == SRst});
    check_eq("oce", {31'd0, oce}, {31'd0, e.st != SRst});
    check_eq("link_up", {31'd0, link_up}, {31'd0, e.st == SAct});
  endtask

  // From the first rst=0 cycle: 4 RESET cycles, 8 TRAIN cycles, then ACTIVE.
  task automatic bring_up();
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (i == 3) ? TW : IW,
                                    (i == 3) ? STrn : SRst);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, (i == 7) ? IW : TW,
                                    (i == 7) ? SAct : STrn);
  endtask

  task automatic train_out();
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (i == 7) ? IW : TW,
                                    (i == 7) ? SAct : STrn);
  endtask

  initial begin
    logic [15:0] wc_exp;
    logic [7:0]  rd;
    logic        rv;
    @(posedge clk);
    #1;
    // Reset held; retrain ignored.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, IW, SRst);
    check_eq("wc_reset", {16'd0, word_count}, 32'd0);
    bring_up();

    // Streaming.
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, SAct);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, SAct);
    cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h03, SAct);
    cyc(1'b0, 8'h04, 1'b0, 1'b0, 1'b1, IW, SAct);
    check_eq("wc_stream", {16'd0, word_count}, 32'd3);

    // Idle gap.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, SAct);
    cyc(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, IW, SAct);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA2, SAct);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, IW, SAct);
    check_eq("wc_gap", {16'd0, word_count}, 32'd5);

    // Retrain in ACTIVE right after a transfer; the word is still shown.
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, SAct);
    cyc(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, TW, STrn);
    train_out();
    check_eq("wc_retrain", {16'd0, word_count}, 32'd6);

    // Retrain pulse at the 5th training word: 13 training words total.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, TW, STrn);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, TW, STrn);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, TW, STrn);
    train_out();

    // Level retrain holds TRAIN until it drops.
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, TW, STrn);
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, TW, STrn);
    train_out();
    check_eq("wc_level", {16'd0, word_count}, 32'd6);

    // Random streaming through the scoreboard.
    wc_exp = 16'd6;
    for (int i = 0; i < 24; i++) begin
      rv = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      cyc(rv, rd, 1'b0, 1'b0, 1'b1, rv ? rd : IW, SAct);
      if (rv) wc_exp++;
    end
    check_eq("wc_random", {16'd0, word_count}, {16'd0, wc_exp});

    // Mid-ACTIVE reset drops the in-flight word and clears the count.
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h42, SAct);
    cyc(1'b1, 8'h43, 1'b0, 1'b1, 1'b0, IW, SRst);
    check_eq("wc_midrst", {16'd0, word_count}, 32'd0);
    bring_up();
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, SAct);
    check_eq("wc_after", {16'd0, word_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oserdes_link_ctrl.md
Name: oserdes_link_ctrl

Overview:
- Sequences one 8:1 OSERDES transmit lane for the chip-to-chip link. Runs in the divided-clock (parallel word) domain.
- Drives the serializer reset and OCE, sends a fixed training word so the far-end deserializer can bit- and word-align, then forwards user bytes through a valid/ready handshake.
- Inserts an idle word whenever no user data is offered.
- Sits between the link framing logic and the oserdese2 wrapper: `d`→d, `oce`→oce, `serdes_rst`→serializer reset.

Parameters:
- RST_CYCLES, 16: clk cycles serdes_rst is held after rst deasserts; must be >= 1.
- TRAIN_CYCLES, 64: number of words for which TRAIN_WORD is sent; must be >= 1.
- TRAIN_WORD, 8'h5C: alignment pattern driven during training.
- IDLE_WORD, 8'hBC: word driven when no data is accepted.
- CNT_W, 16: width of the phase counter; must hold max(RST_CYCLES, TRAIN_CYCLES) - 1.

Ports:
- clk, input, 1: divided (word) clock, same net as the serializer clkdiv.
- rst, input, 1: synchronous, active-high reset.
- serdes_rst, output, 1: active-high reset to the serializer.
- oce, output, 1: serializer output clock enable.
- d, output, 8: parallel word to the serializer; d[0] is transmitted first.
- s_data, input, 8: user byte.
- s_valid, input, 1: s_data is valid.
- s_ready, output, 1: controller accepts s_data this cycle.
- retrain, input, 1: single-cycle or level request to re-run training.
- link_up, output, 1: high in the ACTIVE state.
- state, output, 2: current state. RESET=2'b00, TRAIN=2'b01, ACTIVE=2'b10; 2'b11 is unused.
- word_count, output, 16: count of accepted user words; wraps at 16'hFFFF -> 0.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state is updated on the rising edge of clk.
  - Reset is synchronous and active-high.
  - While rst=1, on each edge: state=RESET, phase counter=RST_CYCLES-1, serdes_rst=1, oce=0, d=IDLE_WORD, link_up=0, word_count=0.
  - s_ready is combinational: s_ready = (state==ACTIVE) && !retrain && !rst. It is therefore 0 during reset.
- RESET state:
  - Outputs: serdes_rst=1, oce=0, d=IDLE_WORD.
  - Counter decrements each cycle. At count==0 the next state is TRAIN and the counter loads TRAIN_CYCLES-1.
  - Result: serdes_rst stays high for exactly RST_CYCLES cycles after the first cycle with rst=0.
- TRAIN state:
  - Outputs: serdes_rst=0, oce=1, d=TRAIN_WORD on every TRAIN cycle.
  - Counter decrements each cycle. At count==0 the next state is ACTIVE.
  - Training therefore lasts exactly TRAIN_CYCLES cycles.
  - retrain=1 while in TRAIN reloads the counter to TRAIN_CYCLES-1, so training restarts.
- ACTIVE state:
  - Outputs: serdes_rst=0, oce=1, link_up=1.
  - A transfer occurs on an edge where s_valid && s_ready.
  - d is registered:
    - After an edge with a transfer, d = s_data of that transfer.
    - After an edge without a transfer, d = IDLE_WORD.
    - The first ACTIVE cycle shows IDLE_WORD.
  - Latency is 1 cycle from acceptance to d.
  - Back-to-back transfers are allowed every cycle, giving full throughput with no bubbles.
  - word_count increments by 1 on each transfer.
- retrain in ACTIVE:
  - In the retrain cycle s_ready=0, so no transfer occurs.
  - Next cycle: state=TRAIN, link_up=0, d=TRAIN_WORD, counter=TRAIN_CYCLES-1.
  - A word accepted in the cycle before retrain still appears on d in the retrain cycle and is not lost.
  - word_count is preserved across retrain and cleared only by rst.
- Level retrain:
  - Held high, it keeps TRAIN restarting and ACTIVE is never entered.
  - TRAIN is left TRAIN_CYCLES cycles after retrain drops.
- retrain in RESET is ignored.
- rst mid-operation (any state) returns to RESET on the next edge. An in-flight word on d is replaced by IDLE_WORD.
- s_data and s_valid are don't-care unless s_ready=1. The upstream source must hold s_data/s_valid until accepted (AXI-Stream style); the controller does not enforce this.
- The state encoding 2'b11 must recover to RESET on the next edge.

Test Plan:
- Reset sequence (RST_CYCLES=4, TRAIN_CYCLES=8): drop rst at cycle 0 -> serdes_rst=1 and oce=0 for cycles 0..3; d=8'h5C with oce=1 for cycles 4..11; link_up=1 and d=8'hBC at cycle 12.
- Streaming in ACTIVE: s_valid=1 with s_data 8'h01,8'h02,8'h03 on consecutive cycles -> d=8'h01,8'h02,8'h03 on the following three cycles, then 8'hBC once s_valid=0; word_count=3.
- Idle gaps: s_valid pattern 1,0,1 with data 8'hA1,x,8'hA2 -> d = A1, BC, A2; word_count +2.
- Retrain in ACTIVE: pulse retrain for 1 cycle with s_valid=1 -> s_ready=0 that cycle; next 8 cycles d=8'h5C and link_up=0; then ACTIVE resumes; word_count unchanged.
- Retrain during TRAIN at 5th training word -> training extends to 8 more words after the pulse (13 TRAIN_WORD cycles total).
- Mid-ACTIVE rst for 1 cycle -> next cycle state=RESET, serdes_rst=1, oce=0, d=8'hBC, word_count=0; full RESET/TRAIN sequence repeats.
